// File: rtl/uart_tx_top.sv
// UART transmitter: serialises one FIFO word per frame (start, 5-8 data bits LSB first,
// optional parity, 1/1.5/2 stop bits), with all bit timing counted in baud_pulse strobes.
module uart_tx_top #(
    parameter int OSR = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       thre,
    input  logic [7:0] din,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic       stb,
    input  logic       set_break,
    output logic       pop,
    output logic       sreg_empty,
    output logic       tx
);

    localparam int CW = $clog2(OSR);
    localparam int SW = $clog2(2 * OSR);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] stop_cnt_q, stop_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [1:0]    wls_q, wls_d;
    logic          pen_q, pen_d;
    logic          stb_q, stb_d;
    logic          par_q, par_d;
    logic          line_q, line_d;
    logic          tx_q, tx_d;
    logic          pop_q, pop_d;
    logic          empty_q, empty_d;

    logic [7:0]    din_masked;
    logic          par_new;
    logic [2:0]    last_idx;
    logic [SW-1:0] stop_last;
    logic          bit_end;
    logic          load;

    // Unused upper data bits are cleared at load so parity only sees the N sent bits.
    assign din_masked = din & (8'hFF >> (2'd3 - wls));
    assign par_new    = sticky_parity ? ~eps : (eps ? ^din_masked : ~^din_masked);
    assign last_idx   = {1'b0, wls_q} + 3'd4;
    assign bit_end    = baud_pulse && (cnt_q == CW'(OSR - 1));

    always_comb begin
        if (!stb_q) begin
            stop_last = SW'(OSR - 1);
        end else if (wls_q == 2'b00) begin
            stop_last = SW'(OSR + OSR / 2 - 1);
        end else begin
            stop_last = SW'(2 * OSR - 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        wls_d      = wls_q;
        pen_d      = pen_q;
        stb_d      = stb_q;
        par_d      = par_q;
        line_d     = line_q;
        empty_d    = empty_q;
        pop_d      = 1'b0;
        load       = 1'b0;

        case (state_q)
            IDLE: begin
                load = baud_pulse && !thre;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    line_d    = shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == last_idx) begin
                        if (pen_q) begin
                            state_d = PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d    = STOP;
                            line_d     = 1'b1;
                            stop_cnt_d = '0;
                        end
                    end else begin
                        line_d    = shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    line_d     = 1'b1;
                    stop_cnt_d = '0;
                end
            end
            STOP: begin
                if (baud_pulse) begin
                    if (stop_cnt_q == stop_last) begin
                        // Chain straight into the next frame when data is waiting.
                        if (!thre) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            empty_d = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
                empty_d = 1'b1;
            end
        endcase

        if (baud_pulse && (state_q == START || state_q == DATA || state_q == PARITY)) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        if (load) begin
            state_d    = START;
            line_d     = 1'b0;
            cnt_d      = '0;
            stop_cnt_d = '0;
            bit_idx_d  = 3'd0;
            shreg_d    = din_masked;
            wls_d      = wls;
            pen_d      = pen;
            stb_d      = stb;
            par_d      = par_new;
            pop_d      = 1'b1;
            empty_d    = 1'b0;
        end

        // Break overrides the line without disturbing the frame sequencing.
        tx_d = set_break ? 1'b0 : line_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stop_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            wls_q      <= 2'b00;
            pen_q      <= 1'b0;
            stb_q      <= 1'b0;
            par_q      <= 1'b0;
            line_q     <= 1'b1;
            tx_q       <= 1'b1;
            pop_q      <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            wls_q      <= wls_d;
            pen_q      <= pen_d;
            stb_q      <= stb_d;
            par_q      <= par_d;
            line_q     <= line_d;
            tx_q       <= tx_d;
            pop_q      <= pop_d;
            empty_q    <= empty_d;
        end
    end

    assign pop        = pop_q;
    assign sreg_empty = empty_q;
    assign tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Bench for uart_tx_top: directed and random frames compared strobe-by-strobe
// against a frame model built from the line-format rules.
module tb_uart_tx_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_pulse;
    logic       thre;
    logic [7:0] din;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
    logic       stb;
    logic       set_break;
    logic       pop;
    logic       sreg_empty;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;
    int pop_cnt  = 0;
    int gap      = 6;
    bit exp_q[$];

    uart_tx_top #(.OSR(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_pulse   (baud_pulse),
        .thre         (thre),
        .din          (din),
        .wls          (wls),
        .pen          (pen),
        .eps          (eps),
        .sticky_parity(sticky_parity),
        .stb          (stb),
        .set_break    (set_break),
        .pop          (pop),
        .sreg_empty   (sreg_empty),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pop === 1'b1) pop_cnt <= pop_cnt + 1;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One baud strobe; returns at the falling edge right after the strobe edge.
    task automatic tick();
        repeat (gap - 1) @(negedge clk);
        baud_pulse = 1'b1;
        @(negedge clk);
        baud_pulse = 1'b0;
    endtask

    // Expected line level for every strobe of a frame, index 0 = load strobe.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] w,
                               input logic p, input logic e, input logic s, input logic sb);
        int n, ones, stop_len;
        bit pb;
        exp_q.delete();
        n    = int'(w) + 5;
        ones = 0;
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            ones += int'(d[i]);
            repeat (16) exp_q.push_back(d[i]);
        end
        if (p) begin
            if (s)      pb = !e;
            else if (e) pb = (ones % 2) == 1;
            else        pb = (ones % 2) == 0;
            repeat (16) exp_q.push_back(pb);
        end
        if (!sb)         stop_len = 16;
        else if (w == 0) stop_len = 24;
        else             stop_len = 32;
        repeat (stop_len) exp_q.push_back(1'b1);
    endtask

    task automatic play(input string name, input logic [7:0] d, input logic [1:0] w,
                        input logic p, input logic e, input logic s, input logic sb,
                        input bit keep_thre, input int brk_from, input int brk_to);
        int  pops0;
        bit  want;
        build_frame(d, w, p, e, s, sb);
        din = d; wls = w; pen = p; eps = e; sticky_parity = s; stb = sb;
        thre  = 1'b0;
        pops0 = pop_cnt;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == brk_from) set_break = 1'b1;
            if (k == brk_to)   set_break = 1'b0;
            tick();
            if (k == 0) begin
                n_checks++;
                if (pop !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s pop after load: got %b want 1", name, pop);
                end
                if (!keep_thre) thre = 1'b1;
                din = 8'($urandom); wls = 2'($urandom); pen = 1'($urandom);
                eps = 1'($urandom); sticky_parity = 1'($urandom); stb = 1'($urandom);
            end
            want = set_break ? 1'b0 : exp_q[k];
            n_checks++;
            if (tx !== want) begin
                n_fail++;
                $display("FAIL %s tx strobe %0d: got %b want %b", name, k, tx, want);
            end
            n_checks++;
            if (sreg_empty !== 1'b0) begin
                n_fail++;
                $display("FAIL %s sreg_empty strobe %0d: got %b want 0", name, k, sreg_empty);
            end
        end
        set_break = 1'b0;
        n_checks++;
        if (pop_cnt - pops0 != 1) begin
            n_fail++;
            $display("FAIL %s pop count: got %0d want 1", name, pop_cnt - pops0);
        end
    endtask

    task automatic finish_idle(input string name);
        thre = 1'b1;
        tick();
        n_checks++;
        if (tx !== 1'b1 || sreg_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle after stop: got tx=%b empty=%b want tx=1 empty=1",
                     name, tx, sreg_empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; baud_pulse = 1'b0; thre = 1'b0; din = 8'h55; wls = 2'b11;
        pen = 1'b0; eps = 1'b0; sticky_parity = 1'b0; stb = 1'b0; set_break = 1'b0;
        tick();
        tick();
        n_checks++;
        if (tx !== 1'b1 || pop !== 1'b0 || sreg_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL reset state: got tx=%b pop=%b empty=%b want 1 0 1", tx, pop, sreg_empty);
        end
        thre = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_8e1();
        gap = 6;
        play("8e1_0x45", 8'h45, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
        finish_idle("8e1_0x45");
    endtask

    task automatic test_5n15();
        gap = 6;
        play("5n15_0xff", 8'hFF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        finish_idle("5n15_0xff");
    endtask

    task automatic test_stick_parity();
        gap = 3;
        play("stick_eps0", 8'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, -1);
        finish_idle("stick_eps0");
        play("stick_eps1", 8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
        finish_idle("stick_eps1");
    endtask

    task automatic test_back_to_back();
        gap = 4;
        play("b2b_a5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1);
        play("b2b_3c", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        finish_idle("b2b_3c");
    endtask

    task automatic test_break();
        gap = 5;
        play("break_data", 8'h9B, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 20, 70);
        finish_idle("break_data");
    endtask

    task automatic test_reset_midframe();
        gap = 6;
        din = 8'hC3; wls = 2'b11; pen = 1'b1; eps = 1'b0; sticky_parity = 1'b0; stb = 1'b0;
        thre = 1'b0;
        tick();
        n_checks++;
        if (pop !== 1'b1 || tx !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid load: got pop=%b tx=%b want 1 0", pop, tx);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (tx !== 1'b1 || sreg_empty !== 1'b1 || pop !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid async: got tx=%b empty=%b pop=%b want 1 1 0", tx, sreg_empty, pop);
        end
        thre = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (tx !== 1'b1 || sreg_empty !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_mid idle wait %0d: got tx=%b empty=%b want 1 1", i, tx, sreg_empty);
            end
        end
        play("after_rst", 8'h5A, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
        finish_idle("after_rst");
    endtask

    task automatic test_random();
        bit keep;
        int bf, bt;
        for (int i = 0; i < 12; i++) begin
            gap  = $urandom_range(2, 7);
            keep = (i != 11) && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                bf = $urandom_range(1, 60);
                bt = bf + $urandom_range(1, 30);
            end else begin
                bf = -1;
                bt = -1;
            end
            play($sformatf("rand%0d", i), 8'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), keep, bf, bt);
            if (!keep) finish_idle($sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_8e1();
        test_5n15();
        test_stick_parity();
        test_back_to_back();
        test_break();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
